// File: rtl/fetch_predict_stage.sv
// Fetch stage with a 32-entry bimodal branch predictor and IF/ID register.
// Word-addressed 5-bit PC; decode-side squash via mispredict or flush.
module fetch_predict_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    output logic [4:0]  imem_addr,
    input  logic [31:0] instr_in,
    input  logic        resolve_valid,
    input  logic [4:0]  resolve_pc,
    input  logic        resolve_taken,
    input  logic        resolve_pred,
    input  logic [4:0]  resolve_target,
    output logic [31:0] instr_d,
    output logic [4:0]  pc_d,
    output logic [4:0]  pcplus1_d,
    output logic        pred_taken_d,
    output logic        valid_d,
    output logic        mispredict,
    output logic [7:0]  mispredict_cnt
);

    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;

    logic [4:0] pc;
    logic [4:0] pc_next;
    logic [4:0] pc_plus1;
    logic [4:0] pred_target;
    logic [4:0] redirect_pc;
    logic [4:0] b_off;
    logic [4:0] j_off;
    logic [1:0] ctr [32];
    logic [1:0] ctr_rd;
    logic [1:0] ctr_wr;
    logic       is_b;
    logic       is_jal;
    logic       pred_taken;

    assign imem_addr = pc;
    assign pc_plus1  = pc + 5'd1;
    assign ctr_rd    = ctr[pc];

    // Only byte-immediate bits [6:2] survive the >>2 and mod-32 wrap.
    assign b_off = {instr_in[26:25], instr_in[11:9]};
    assign j_off = instr_in[26:22];

    always_comb begin
        is_b   = 1'b0;
        is_jal = 1'b0;
        case (instr_in[6:0])
            OP_BRANCH: is_b   = 1'b1;
            OP_JAL:    is_jal = 1'b1;
            default:   ;
        endcase
    end

    assign pred_taken  = is_jal | (is_b & ctr_rd[1]);
    assign pred_target = pc + (is_jal ? j_off : b_off);

    assign mispredict  = resolve_valid && (resolve_taken != resolve_pred);
    assign redirect_pc = resolve_taken ? resolve_target : resolve_pc + 5'd1;

    always_comb begin
        pc_next = pc_plus1;
        if (mispredict)
            pc_next = redirect_pc;
        else if (stall)
            pc_next = pc;
        else if (pred_taken)
            pc_next = pred_target;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            pc <= 5'd0;
        else
            pc <= pc_next;
    end

    // Squash wins over stall so a redirect never leaves a stale slot.
    always_ff @(posedge clk) begin
        if (!reset || mispredict || flush) begin
            instr_d      <= NOP;
            pc_d         <= 5'd0;
            pcplus1_d    <= 5'd0;
            pred_taken_d <= 1'b0;
            valid_d      <= 1'b0;
        end else if (!stall) begin
            instr_d      <= instr_in;
            pc_d         <= pc;
            pcplus1_d    <= pc_plus1;
            pred_taken_d <= pred_taken;
            valid_d      <= 1'b1;
        end
    end

    always_comb begin
        ctr_wr = ctr[resolve_pc];
        if (resolve_taken && ctr_wr != 2'b11)
            ctr_wr = ctr_wr + 2'd1;
        else if (!resolve_taken && ctr_wr != 2'b00)
            ctr_wr = ctr_wr - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++)
                ctr[i] <= 2'b01;
        end else if (resolve_valid) begin
            ctr[resolve_pc] <= ctr_wr;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)
            mispredict_cnt <= 8'd0;
        else if (mispredict && mispredict_cnt != 8'hff)
            mispredict_cnt <= mispredict_cnt + 8'd1;
    end

endmodule

// File: tb/tb_fetch_predict_stage.sv
// Directed bench for fetch_predict_stage.
// Instruction memory is a bench array read combinationally.
module tb_fetch_predict_stage;

    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] JAL4 = 32'h010000ef;
    localparam logic [31:0] BR3  = 32'h00000663;
    localparam logic [31:0] ADDI = 32'h00100093;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [4:0]  imem_addr;
    logic [31:0] instr_in;
    logic        resolve_valid;
    logic [4:0]  resolve_pc;
    logic        resolve_taken;
    logic        resolve_pred;
    logic [4:0]  resolve_target;
    logic [31:0] instr_d;
    logic [4:0]  pc_d;
    logic [4:0]  pcplus1_d;
    logic        pred_taken_d;
    logic        valid_d;
    logic        mispredict;
    logic [7:0]  mispredict_cnt;

    logic [31:0] imem [32];
    int checks = 0;
    int errors = 0;

    assign instr_in = imem[imem_addr];

    always #5 clk = ~clk;

    fetch_predict_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .imem_addr      (imem_addr),
        .instr_in       (instr_in),
        .resolve_valid  (resolve_valid),
        .resolve_pc     (resolve_pc),
        .resolve_taken  (resolve_taken),
        .resolve_pred   (resolve_pred),
        .resolve_target (resolve_target),
        .instr_d        (instr_d),
        .pc_d           (pc_d),
        .pcplus1_d      (pcplus1_d),
        .pred_taken_d   (pred_taken_d),
        .valid_d        (valid_d),
        .mispredict     (mispredict),
        .mispredict_cnt (mispredict_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic resolve(input logic [4:0] p, input logic t,
                           input logic pr, input logic [4:0] tg);
        resolve_valid  = 1'b1;
        resolve_pc     = p;
        resolve_taken  = t;
        resolve_pred   = pr;
        resolve_target = tg;
    endtask

    task automatic unresolve();
        resolve_valid = 1'b0;
        resolve_taken = 1'b0;
        resolve_pred  = 1'b0;
    endtask

    // Mispredict on unrelated pc 31 just to steer fetch back to 5.
    task automatic go_to5();
        resolve(5'd31, 1'b1, 1'b0, 5'd5);
        step();
        unresolve();
    endtask

    initial begin
        for (int i = 0; i < 32; i++)
            imem[i] = NOP;
        reset = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        resolve_pc = 5'd0;
        resolve_target = 5'd0;
        resolve(5'd5, 1'b1, 1'b0, 5'd9);
        step();
        step();
        chk("rst_addr", imem_addr, 0);
        chk("rst_valid", valid_d, 0);
        chk("rst_instr", instr_d, NOP);
        chk("rst_pred", pred_taken_d, 0);
        chk("rst_cnt", mispredict_cnt, 0);

        reset = 1'b1;
        unresolve();
        for (int i = 1; i <= 32; i++) begin
            step();
            chk("seq_addr", imem_addr, i % 32);
            chk("seq_pc_d", pc_d, i - 1);
            chk("seq_pcp1", pcplus1_d, i % 32);
            chk("seq_valid", valid_d, 1);
        end

        imem[3] = JAL4;
        imem[5] = BR3;
        step();
        step();
        step();
        chk("pre_jal", imem_addr, 3);
        step();
        chk("jal_addr", imem_addr, 7);
        chk("jal_pred", pred_taken_d, 1);
        chk("jal_pcp1", pcplus1_d, 4);
        chk("jal_pc_d", pc_d, 3);
        chk("jal_instr", instr_d, JAL4);

        resolve(5'd31, 1'b1, 1'b0, 5'd5);
        #1;
        chk("mp_comb", mispredict, 1);
        step();
        unresolve();
        chk("mp_addr", imem_addr, 5);
        chk("mp_valid", valid_d, 0);
        chk("mp_instr", instr_d, NOP);
        chk("mp_cnt1", mispredict_cnt, 1);

        step();
        chk("b01_addr", imem_addr, 6);
        chk("b01_pred", pred_taken_d, 0);
        chk("b01_instr", instr_d, BR3);

        resolve(5'd5, 1'b1, 1'b1, 5'd8);
        #1;
        chk("nomp_comb", mispredict, 0);
        step();
        step();
        unresolve();
        go_to5();
        chk("cnt2", mispredict_cnt, 2);
        step();
        chk("b11_addr", imem_addr, 8);
        chk("b11_pred", pred_taken_d, 1);

        resolve(5'd5, 1'b1, 1'b1, 5'd8);
        step();
        resolve(5'd5, 1'b0, 1'b0, 5'd8);
        step();
        unresolve();
        go_to5();
        resolve(5'd5, 1'b0, 1'b0, 5'd8);
        step();
        unresolve();
        chk("sat_addr", imem_addr, 8);
        chk("sat_pred", pred_taken_d, 1);
        go_to5();
        step();
        chk("b01b_addr", imem_addr, 6);
        chk("b01b_pred", pred_taken_d, 0);
        chk("cnt4", mispredict_cnt, 4);

        imem[20] = ADDI;
        resolve(5'd9, 1'b1, 1'b0, 5'd20);
        stall = 1'b1;
        #1;
        chk("smp_comb", mispredict, 1);
        step();
        unresolve();
        stall = 1'b0;
        chk("smp_addr", imem_addr, 20);
        chk("smp_valid", valid_d, 0);
        chk("smp_instr", instr_d, NOP);
        chk("smp_cnt", mispredict_cnt, 5);

        step();
        chk("pre_stall", instr_d, ADDI);
        stall = 1'b1;
        resolve(5'd5, 1'b1, 1'b1, 5'd8);
        for (int k = 0; k < 3; k++) begin
            step();
            unresolve();
            chk("st_addr", imem_addr, 21);
            chk("st_instr", instr_d, ADDI);
            chk("st_pc_d", pc_d, 20);
            chk("st_valid", valid_d, 1);
        end
        stall = 1'b0;
        go_to5();
        step();
        chk("st_ctr", imem_addr, 8);

        resolve(5'd5, 1'b1, 1'b0, 5'd9);
        reset = 1'b0;
        step();
        chk("mrst_addr", imem_addr, 0);
        chk("mrst_cnt", mispredict_cnt, 0);
        chk("mrst_valid", valid_d, 0);
        reset = 1'b1;
        unresolve();
        imem[3] = NOP;
        for (int k = 0; k < 5; k++)
            step();
        chk("mrst_at5", imem_addr, 5);
        step();
        chk("mrst_nt", imem_addr, 6);
        chk("mrst_pred", pred_taken_d, 0);
        resolve(5'd5, 1'b1, 1'b1, 5'd8);
        step();
        unresolve();
        go_to5();
        chk("mrst_cnt1", mispredict_cnt, 1);
        step();
        chk("mrst_ctr10", imem_addr, 8);

        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_valid", valid_d, 0);
        chk("fl_instr", instr_d, NOP);
        chk("fl_addr", imem_addr, 9);

        resolve(5'd31, 1'b1, 1'b0, 5'd5);
        for (int k = 0; k < 260; k++)
            step();
        unresolve();
        chk("cnt_sat", mispredict_cnt, 255);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
